main_memory: RTL and testbench
==============================

MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 The block SHALL have parameter CORES, default 32, meaning lanes per memory word.
REQ-002 The block SHALL have parameter BITS, default 16, meaning bits per lane; word width W = CORES*BITS.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning number of words implemented.
REQ-004 The block SHALL have parameter LATENCY, default 2, legal range 1..4, meaning cycles from load acceptance to load_valid.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port load_ctrl, input, 1, load request.
REQ-008 The block SHALL have port load_addr, input, 16, load word address.
REQ-009 The block SHALL have port load_ready, output, 1, high when a load is accepted this cycle.
REQ-010 The block SHALL have port load_data, output, W, returned load word.
REQ-011 The block SHALL have port load_valid, output, 1, one-cycle strobe qualifying load_data.
REQ-012 The block SHALL have port write_ctrl, input, 1, write request, always accepted.
REQ-013 The block SHALL have port write_addr_main, input, 16, write word address.
REQ-014 The block SHALL have port write_data_main, input, W, write word.
REQ-015 The block SHALL have port addr_error, output, 1, one-cycle strobe flagging an out-of-range access.

Function
REQ-016 Memory SHALL be single-ported: at most one access (load or write) commits per rising edge.
REQ-017 A write SHALL commit at the edge where write_ctrl=1 and write_addr_main<DEPTH.
REQ-018 With both load_ctrl and write_ctrl high, the write SHALL win and load_ready SHALL be 0.
REQ-019 The requester SHALL hold the load until load_ready=1.
REQ-020 load_ready SHALL equal load_ctrl & !write_ctrl & !reset.
REQ-021 An accepted load SHALL read the array at the acceptance edge.
REQ-022 The read word SHALL then pass through a LATENCY-1 stage valid/data delay line, with load_valid asserted exactly LATENCY cycles after acceptance.
REQ-023 Loads SHALL be fully pipelined: back-to-back accepted loads produce back-to-back load_valid pulses, in order.
REQ-024 A load accepted the cycle after a write to the same address SHALL return the newly written data (read-after-write, no stale data).
REQ-025 A load with load_addr>=DEPTH SHALL be accepted normally, return all-zero load_data with load_valid at normal latency, and pulse addr_error the cycle after acceptance.
REQ-026 A write with write_addr_main>=DEPTH SHALL leave the array unchanged and pulse addr_error the next cycle.
REQ-027 load_data SHALL hold its last value while load_valid=0.

Reset
REQ-028 While reset=1, the block SHALL drive load_ready=0, load_valid=0, addr_error=0 and load_data=0.
REQ-029 While reset=1, the block SHALL clear every delay-line valid bit.
REQ-030 Loads in flight when reset asserts SHALL be dropped, with no load_valid afterwards.
REQ-031 Reset SHALL NOT clear array contents.
REQ-032 Writes presented during reset SHALL be ignored.

Configuration
REQ-033 With macro MAIN_MEMORY_STATS_EN defined, the block SHALL add 32-bit outputs load_count and write_count.
REQ-034 load_count and write_count SHALL count accepted loads and committed in-range writes respectively.
REQ-035 load_count and write_count SHALL saturate at 32'hFFFFFFFF.
REQ-036 load_count and write_count SHALL be cleared by reset.
REQ-037 Without MAIN_MEMORY_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-038 Shared package mem_pkg SHALL hold the address width constant (16), the LATENCY bounds (1..4) and a mem_req_t typedef (addr, ctrl).
REQ-039 The delay line SHALL be a sub-module mem_read_pipe, parameterised by width and depth, carrying a valid bit plus data.
REQ-040 The top level SHALL hold the array, arbitration and error logic.

Verification
REQ-041 The bench SHALL cover basic load: with CORES=32, BITS=16, write addr 5 data {32{16'h3F80}}, then load addr 5 -> load_valid 2 cycles after acceptance, load_data={32{16'h3F80}}.
REQ-042 The bench SHALL cover collision: write_ctrl and load_ctrl both high in the same cycle, with write addr 7=A and load addr 7 -> load_ready=0 that cycle, load accepted the next cycle, returns A.
REQ-043 The bench SHALL cover streaming: loads of addrs 0,1,2,3 on 4 consecutive cycles -> 4 consecutive load_valid pulses with data in address order.
REQ-044 The bench SHALL cover out of range: with DEPTH=1024, load addr 16'd2000 -> addr_error pulse, load_data=0 at normal latency; write addr 16'd1024 -> addr_error pulse and array unchanged.
REQ-045 The bench SHALL cover reset mid-flight: accept load, assert reset the next cycle -> no load_valid ever; after reset, earlier data is still readable.
REQ-046 The bench SHALL cover stats: with MAIN_MEMORY_STATS_EN defined, issue 3 loads and 2 in-range writes plus 1 out-of-range write -> load_count=3, write_count=2.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and request type for the main_memory block.
package mem_pkg;
   localparam int ADDR_W  = 16;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              ctrl;
   } mem_req_t;
endpackage

// File: rtl/mem_read_pipe.sv
// Valid/data delay line for the read path.
// Each data stage only loads when its incoming valid is set, so the output holds its last word.
module mem_read_pipe #(
   parameter int WIDTH  = 512,
   parameter int STAGES = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);
   generate
      if (STAGES == 0) begin : g_pass
         assign out_valid = in_valid;
         assign out_data  = in_data;
      end else begin : g_pipe
         logic [STAGES:1]            vld_pipe;
         logic [STAGES:1][WIDTH-1:0] dat_pipe;

         always_ff @(posedge clock) begin
            if (reset) begin
               vld_pipe <= '0;
               dat_pipe <= '0;
            end else begin
               vld_pipe[1] <= in_valid;
               if (in_valid) dat_pipe[1] <= in_data;
               for (int s = 2; s <= STAGES; s++) begin
                  vld_pipe[s] <= vld_pipe[s-1];
                  if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
               end
            end
         end

         assign out_valid = vld_pipe[STAGES];
         assign out_data  = dat_pipe[STAGES];
      end
   endgenerate
endmodule

// File: rtl/main_memory.sv
// Single-ported word memory, writes win arbitration, pipelined loads (LATENCY 1..4).
// Optional MAIN_MEMORY_STATS_EN adds saturating load/write counters.
module main_memory
   import mem_pkg::*;
#(
   parameter int CORES   = 32,
   parameter int BITS    = 16,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load_ctrl,
   input  logic [ADDR_W-1:0]       load_addr,
   output logic                    load_ready,
   output logic [CORES*BITS-1:0]   load_data,
   output logic                    load_valid,
   input  logic                    write_ctrl,
   input  logic [ADDR_W-1:0]       write_addr_main,
   input  logic [CORES*BITS-1:0]   write_data_main,
   output logic                    addr_error
`ifdef MAIN_MEMORY_STATS_EN
   ,
   output logic [31:0]             load_count,
   output logic [31:0]             write_count
`endif
);
   localparam int W  = CORES * BITS;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   mem_req_t ld, wr;
   logic     ld_in, wr_in, ld_acc, wr_ok;
   logic     rd_vld, err_q, pv;
   logic [W-1:0] rd_data, pd;
   logic [W-1:0] mem [DEPTH];

   assign ld = '{addr: load_addr, ctrl: load_ctrl};
   assign wr = '{addr: write_addr_main, ctrl: write_ctrl};

   assign ld_in  = 32'(ld.addr) < DEPTH;
   assign wr_in  = 32'(wr.addr) < DEPTH;
   assign ld_acc = ld.ctrl & ~wr.ctrl & ~reset;
   assign wr_ok  = wr.ctrl & wr_in & ~reset;
   assign load_ready = ld_acc;

   // Array has no reset; contents survive reset.
   always_ff @(posedge clock) begin
      if (wr_ok) mem[wr.addr[IW-1:0]] <= write_data_main;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_vld  <= 1'b0;
         rd_data <= '0;
         err_q   <= 1'b0;
      end else begin
         rd_vld <= ld_acc;
         if (ld_acc) rd_data <= ld_in ? mem[ld.addr[IW-1:0]] : '0;
         err_q <= (wr.ctrl & ~wr_in) | (ld_acc & ~ld_in);
      end
   end

   mem_read_pipe #(.WIDTH(W), .STAGES(LATENCY-1)) u_pipe (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (rd_vld),
      .in_data   (rd_data),
      .out_valid (pv),
      .out_data  (pd)
   );

   // Outputs forced quiet for the whole reset cycle, not just after the edge.
   assign load_valid = pv & ~reset;
   assign load_data  = reset ? '0 : pd;
   assign addr_error = err_q & ~reset;

`ifdef MAIN_MEMORY_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         load_count  <= '0;
         write_count <= '0;
      end else begin
         if (ld_acc && load_count  != 32'hFFFF_FFFF) load_count  <= load_count + 32'd1;
         if (wr_ok  && write_count != 32'hFFFF_FFFF) write_count <= write_count + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory (default parameters, LATENCY=2).
module tb_main_memory;
   localparam int W = 512;

   logic          clock = 1'b0;
   logic          reset;
   logic          load_ctrl, write_ctrl, load_ready, load_valid, addr_error;
   logic [15:0]   load_addr, write_addr_main;
   logic [W-1:0]  load_data, write_data_main;
`ifdef MAIN_MEMORY_STATS_EN
   logic [31:0]   load_count, write_count;
`endif

   always #5 clock = ~clock;

   main_memory dut (
      .clock           (clock),
      .reset           (reset),
      .load_ctrl       (load_ctrl),
      .load_addr       (load_addr),
      .load_ready      (load_ready),
      .load_data       (load_data),
      .load_valid      (load_valid),
      .write_ctrl      (write_ctrl),
      .write_addr_main (write_addr_main),
      .write_data_main (write_data_main),
      .addr_error      (addr_error)
`ifdef MAIN_MEMORY_STATS_EN
      ,
      .load_count      (load_count),
      .write_count     (write_count)
`endif
   );

   typedef struct {
      logic          we;
      logic [15:0]   waddr;
      logic [W-1:0]  wdata;
      logic          le;
      logic [15:0]   laddr;
      logic          rdy;
      logic          vld;
      logic [W-1:0]  data;
      logic          err;
   } vec_t;

   vec_t vq[$];
   int   passed = 0;
   int   total  = 0;

   function automatic logic [W-1:0] rep(input logic [15:0] h);
      return {32{h}};
   endfunction

   function automatic vec_t mk(input logic we, input logic [15:0] wa, input logic [W-1:0] wd,
                               input logic le, input logic [15:0] la,
                               input logic rdy, input logic vld, input logic [W-1:0] d, input logic err);
      vec_t v;
      v.we = we; v.waddr = wa; v.wdata = wd; v.le = le; v.laddr = la;
      v.rdy = rdy; v.vld = vld; v.data = d; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      load_ctrl = 0; write_ctrl = 0; load_addr = '0; write_addr_main = '0; write_data_main = '0;
   endtask

   logic [W-1:0] D5, A, BEEF, ZERO;
   int lat;

   initial begin
      D5 = rep(16'h3F80); A = rep(16'hA5A5); BEEF = rep(16'hBEEF); ZERO = '0;
      reset = 1; idle();
      load_ctrl = 1; load_addr = 16'd3;
      tick(); tick();
      chk("rst_ready", W'(load_ready), W'(1'b0));
      chk("rst_valid", W'(load_valid), W'(1'b0));
      chk("rst_err",   W'(addr_error), W'(1'b0));
      chk("rst_data",  load_data, ZERO);
      reset = 0; idle();

      //        we wa      wdata         le la       rdy vld data  err
      vq.push_back(mk(1, 16'd5,  D5,            0, 16'd0,    0, 0, ZERO, 0)); // 0
      vq.push_back(mk(0, 16'd0,  ZERO,          1, 16'd5,    1, 0, ZERO, 0)); // 1 accept
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 0, ZERO, 0));
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 1, D5,   0)); // 3 basic load
      vq.push_back(mk(1, 16'd7,  A,             1, 16'd7,    0, 0, D5,   0)); // 4 collision
      vq.push_back(mk(0, 16'd0,  ZERO,          1, 16'd7,    1, 0, D5,   0)); // 5 retry
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 0, D5,   0));
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 1, A,    0)); // 7
      for (int i = 0; i < 4; i++)
         vq.push_back(mk(1, 16'(i), rep(16'h1000 + 16'(i)), 0, 16'd0, 0, 0, A, 0)); // 8..11
      vq.push_back(mk(0, 16'd0,  ZERO,          1, 16'd0,    1, 0, A,    0)); // 12
      vq.push_back(mk(0, 16'd0,  ZERO,          1, 16'd1,    1, 0, A,    0));
      vq.push_back(mk(0, 16'd0,  ZERO,          1, 16'd2,    1, 1, rep(16'h1000), 0));
      vq.push_back(mk(0, 16'd0,  ZERO,          1, 16'd3,    1, 1, rep(16'h1001), 0));
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 1, rep(16'h1002), 0));
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 1, rep(16'h1003), 0));
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 0, rep(16'h1003), 0)); // 18 hold
      vq.push_back(mk(0, 16'd0,  ZERO,          1, 16'd2000, 1, 0, rep(16'h1003), 0)); // 19 oor load
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 0, rep(16'h1003), 1));
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 1, ZERO, 0));
      vq.push_back(mk(1, 16'd1024, rep(16'hFFFF), 0, 16'd0,  0, 0, ZERO, 0)); // 22 oor write
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 0, ZERO, 1));
      vq.push_back(mk(0, 16'd0,  ZERO,          1, 16'd0,    1, 0, ZERO, 0)); // 24 alias check
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 0, ZERO, 0));
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 1, rep(16'h1000), 0));
      vq.push_back(mk(1, 16'd9,  BEEF,          0, 16'd0,    0, 0, rep(16'h1000), 0)); // 27 RAW
      vq.push_back(mk(0, 16'd0,  ZERO,          1, 16'd9,    1, 0, rep(16'h1000), 0));
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 0, rep(16'h1000), 0));
      vq.push_back(mk(0, 16'd0,  ZERO,          0, 16'd0,    0, 1, BEEF, 0));

      foreach (vq[i]) begin
         write_ctrl = vq[i].we; write_addr_main = vq[i].waddr; write_data_main = vq[i].wdata;
         load_ctrl  = vq[i].le; load_addr = vq[i].laddr;
         #1;
         chk($sformatf("v%0d_ready", i), W'(load_ready), W'(vq[i].rdy));
         chk($sformatf("v%0d_valid", i), W'(load_valid), W'(vq[i].vld));
         chk($sformatf("v%0d_err",   i), W'(addr_error), W'(vq[i].err));
         chk($sformatf("v%0d_data",  i), load_data, vq[i].data);
         tick();
      end
      idle();

      // Reset mid-flight, with a junk write presented during reset.
      load_ctrl = 1; load_addr = 16'd5; #1;
      chk("mf_accept", W'(load_ready), W'(1'b1));
      tick();
      idle(); reset = 1; write_ctrl = 1; write_addr_main = 16'd9; write_data_main = rep(16'h0BAD); #1;
      chk("mf_rst_ready", W'(load_ready), W'(1'b0));
      chk("mf_rst_valid", W'(load_valid), W'(1'b0));
      chk("mf_rst_data",  load_data, ZERO);
      tick();
      reset = 0; idle();
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("mf_novalid%0d", c), W'(load_valid), W'(1'b0));
         tick();
      end
      load_ctrl = 1; load_addr = 16'd9;
      tick();
      idle();
      lat = 1;
      while (!load_valid && lat < 10) begin tick(); lat++; end
      chk("mf_lat", W'(lat), W'(2));
      chk("mf_keep9", load_data, BEEF);
      load_ctrl = 1; load_addr = 16'd5;
      tick(); idle(); tick();
      chk("mf_keep5_v", W'(load_valid), W'(1'b1));
      chk("mf_keep5", load_data, D5);
      tick();

`ifdef MAIN_MEMORY_STATS_EN
      reset = 1; tick(); reset = 0;
      chk("st_clr_l", W'(load_count),  W'(0));
      chk("st_clr_w", W'(write_count), W'(0));
      for (int i = 0; i < 3; i++) begin load_ctrl = 1; load_addr = 16'(i); tick(); end
      idle();
      write_ctrl = 1; write_addr_main = 16'd10; write_data_main = rep(16'h0010); tick();
      write_addr_main = 16'd11; tick();
      write_addr_main = 16'd1024; tick();
      idle(); tick(); tick();
      chk("st_loads",  W'(load_count),  W'(3));
      chk("st_writes", W'(write_count), W'(2));
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
